// File: rtl/vga_pkg.sv
// Shared raster defaults, text-cell geometry and the glyph-code helper for the hex text scanner.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int CHAR_W   = 8;
    localparam int CHAR_H   = 16;
    localparam int TXT_COLS = 8;
    localparam int TXT_ROWS = 8;
    localparam int WIN_W    = CHAR_W * TXT_COLS;
    localparam int WIN_H    = CHAR_H * TXT_ROWS;

    // Wide enough for the 800x525 default raster.
    localparam int CNT_W = 10;

    localparam logic [4:0] ALPH_SPACE = 5'd16;

    // Column 0 is the most significant nibble of the word.
    function automatic logic [4:0] hex_digit(input logic [31:0] w, input logic [2:0] col);
        return {1'b0, w[{3'd7 - col, 2'b00} +: 4]};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider and raster counters with raw sync, active flag and snapshot trigger.
// Latency: combinational outputs decode the current counter values.
// Backpressure: none; free-running raster.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             active,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             snap_trig
);

    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                if (hcnt == CNT_W'(HT - 1)) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == CNT_W'(VT - 1)) ? '0 : vcnt + CNT_W'(1);
                end else begin
                    hcnt <= hcnt + CNT_W'(1);
                end
            end
        end
    end

    assign active = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));
    assign hs_raw = !((hcnt >= CNT_W'(H_ACTIVE + H_FP)) && (hcnt < CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_raw = !((vcnt >= CNT_W'(V_ACTIVE + V_FP)) && (vcnt < CNT_W'(V_ACTIVE + V_FP + V_SYNC)));

    // First pixel of the first vsync line: blanked, so the snapshot never tears.
    assign snap_trig = tick && (hcnt == '0) && (vcnt == CNT_W'(V_ACTIVE + V_FP));

endmodule

// File: rtl/vga_hex_text_scan.sv
// VGA text window showing eight 32-bit words as an 8x8 block of hex digits.
// Latency: a raster position reaches rgb/hs/vs two pixel ticks after its count.
// Backpressure: none; words are sampled once per frame, point is a combinational ROM reply.
module vga_hex_text_scan
    import vga_pkg::*;
#(
    parameter int          CLK_DIV  = 4,
    parameter int          H_ACTIVE = H_ACTIVE_DEF,
    parameter int          H_FP     = H_FP_DEF,
    parameter int          H_SYNC   = H_SYNC_DEF,
    parameter int          H_BP     = H_BP_DEF,
    parameter int          V_ACTIVE = V_ACTIVE_DEF,
    parameter int          V_FP     = V_FP_DEF,
    parameter int          V_SYNC   = V_SYNC_DEF,
    parameter int          V_BP     = V_BP_DEF,
    parameter int          WIN_X    = 256,
    parameter int          WIN_Y    = 176,
    parameter logic [11:0] FG       = 12'hFFF,
    parameter logic [11:0] BG       = 12'h000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] words,
    output logic [2:0]   dH,
    output logic [3:0]   dV,
    output logic [4:0]   alph,
    input  logic         point,
    output logic         hs,
    output logic         vs,
    output logic [11:0]  rgb,
    output logic         frame_start
);

    logic             tick;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic             snap_trig;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [5:0]       hoff;
    logic [6:0]       voff;
    logic             in_win;
    logic             act1;
    logic             hs1;
    logic             vs1;

    logic [TXT_ROWS-1:0][31:0] snapshot;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .active    (active),
        .hs_raw    (hs_raw),
        .vs_raw    (vs_raw),
        .snap_trig (snap_trig)
    );

    // Offsets are only consumed inside the window, where they cannot underflow.
    assign hoff   = 6'(hcnt - CNT_W'(WIN_X));
    assign voff   = 7'(vcnt - CNT_W'(WIN_Y));
    assign in_win = (hcnt >= CNT_W'(WIN_X)) && (hcnt < CNT_W'(WIN_X + WIN_W)) &&
                    (vcnt >= CNT_W'(WIN_Y)) && (vcnt < CNT_W'(WIN_Y + WIN_H));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap_trig;
            if (snap_trig) begin
                snapshot <= words;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dH   <= '0;
            dV   <= '0;
            alph <= ALPH_SPACE;
            act1 <= 1'b0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
            rgb  <= '0;
            hs   <= 1'b1;
            vs   <= 1'b1;
        end else if (tick) begin
            dH   <= in_win ? hoff[2:0] : 3'd0;
            dV   <= in_win ? voff[3:0] : 4'd0;
            alph <= in_win ? hex_digit(snapshot[voff[6:4]], hoff[5:3]) : ALPH_SPACE;
            act1 <= active;
            hs1  <= hs_raw;
            vs1  <= vs_raw;
            // point answers the address registered on the previous tick.
            rgb  <= act1 ? (point ? FG : BG) : 12'h000;
            hs   <= hs1;
            vs   <= vs1;
        end
    end

endmodule

// File: tb/tb_vga_hex_text_scan.sv
// Directed bench on a shrunken raster: one instance at one pixel per clock, one at four clocks per pixel.
module tb_vga_hex_text_scan;

    localparam int HA = 72, HF = 2, HSY = 4, HB = 2;
    localparam int VA = 136, VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int WX = 4, WY = 4;
    localparam logic [11:0] FGC = 12'hA5C;
    localparam logic [11:0] BGC = 12'h123;

    logic         clk = 1'b0;
    logic         rst1 = 1'b1;
    logic         rst4 = 1'b1;
    logic [255:0] words1 = '0;
    logic [255:0] words4 = '0;
    logic [2:0]   dH1, dH4;
    logic [3:0]   dV1, dV4;
    logic [4:0]   alph1, alph4;
    logic         point1, point4;
    logic         hs1, vs1, hs4, vs4;
    logic [11:0]  rgb1, rgb4;
    logic         fs1, fs4;

    int tests = 0;
    int fails = 0;
    int cyc1 = 0;
    int cyc4 = 0;
    int fs_cnt = 0;

    always #5 clk = ~clk;

    // Glyph ROM model: every hex digit is fully lit, the space glyph is blank.
    assign point1 = (alph1 < 5'd16);
    assign point4 = (alph4 < 5'd16);

    vga_hex_text_scan #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .WIN_X(WX), .WIN_Y(WY), .FG(FGC), .BG(BGC)
    ) dut1 (
        .clk(clk), .rst(rst1), .words(words1), .dH(dH1), .dV(dV1), .alph(alph1),
        .point(point1), .hs(hs1), .vs(vs1), .rgb(rgb1), .frame_start(fs1)
    );

    vga_hex_text_scan #(
        .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .WIN_X(WX), .WIN_Y(WY), .FG(FGC), .BG(BGC)
    ) dut4 (
        .clk(clk), .rst(rst4), .words(words4), .dH(dH4), .dV(dV4), .alph(alph4),
        .point(point4), .hs(hs4), .vs(vs4), .rgb(rgb4), .frame_start(fs4)
    );

    // Clock edges since reset release; equals the raster count of the CLK_DIV=1 instance.
    always @(posedge clk) begin
        cyc1 <= rst1 ? 0 : cyc1 + 1;
        cyc4 <= rst4 ? 0 : cyc4 + 1;
        if (fs1) fs_cnt <= fs_cnt + 1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hv(input int h, input int v);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step;
            if ((cyc1 % HT) == h && ((cyc1 / HT) % VT) == v) begin
                tests++;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL wait_hv: raster (%0d,%0d) not reached, cycle %0d", h, v, cyc1);
    endtask

    task automatic test_reset;
        int first;
        rst1 = 1'b1;
        repeat (3) step;
        tests++; if (rgb1 !== 12'h000) begin fails++; $display("FAIL reset_rgb: got %h want 000", rgb1); end
        tests++; if ({hs1, vs1} !== 2'b11) begin fails++; $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", hs1, vs1); end
        tests++; if (alph1 !== 5'd16) begin fails++; $display("FAIL reset_alph: got %0d want 16", alph1); end
        tests++; if ({dH1, dV1, fs1} !== 8'd0) begin fails++; $display("FAIL reset_addr: got dH=%0d dV=%0d fs=%b want 0", dH1, dV1, fs1); end
        @(negedge clk);
        rst1 = 1'b0;
        first = 0;
        for (int n = 1; n <= 200; n++) begin
            step;
            if (hs1 === 1'b0) begin first = n; break; end
        end
        tests++; if (first != HA + HF + 2) begin fails++; $display("FAIL first_hs_fall: got %0d want %0d", first, HA + HF + 2); end
    endtask

    task automatic test_timing;
        logic ph, pv;
        int hs_falls, hs_bad_int, hs_bad_run, hs_run, hs_last;
        int vs_falls, vs_bad_int, vs_bad_run, vs_run, vs_last, vs_first;
        ph = 1'b0; pv = 1'b1;
        hs_falls = 0; hs_bad_int = 0; hs_bad_run = 0; hs_run = 1; hs_last = cyc1;
        vs_falls = 0; vs_bad_int = 0; vs_bad_run = 0; vs_run = 0; vs_last = 0; vs_first = -1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step;
            if (hs1 === 1'b0) begin
                if (ph) begin
                    hs_falls++;
                    if (cyc1 - hs_last != HT) hs_bad_int++;
                    hs_last = cyc1;
                    hs_run = 1;
                end else hs_run++;
            end else if (!ph && hs_run != HSY) hs_bad_run++;
            if (vs1 === 1'b0) begin
                if (pv) begin
                    if (vs_falls == 0) vs_first = cyc1;
                    else if (cyc1 - vs_last != FRAME) vs_bad_int++;
                    vs_falls++;
                    vs_last = cyc1;
                    vs_run = 1;
                end else vs_run++;
            end else if (!pv && vs_run != VSY * HT) vs_bad_run++;
            ph = hs1;
            pv = vs1;
        end
        tests++; if (hs_falls != 3 * VT) begin fails++; $display("FAIL hs_fall_count: got %0d want %0d", hs_falls, 3 * VT); end
        tests++; if (hs_bad_int != 0) begin fails++; $display("FAIL hs_period: %0d lines off, want 0", hs_bad_int); end
        tests++; if (hs_bad_run != 0) begin fails++; $display("FAIL hs_width: %0d pulses off, want 0", hs_bad_run); end
        tests++; if (vs_falls != 3) begin fails++; $display("FAIL vs_fall_count: got %0d want 3", vs_falls); end
        tests++; if (vs_first != (VA + VF) * HT + 2) begin fails++; $display("FAIL vs_first_fall: got %0d want %0d", vs_first, (VA + VF) * HT + 2); end
        tests++; if (vs_bad_int != 0) begin fails++; $display("FAIL vs_period: %0d frames off, want 0", vs_bad_int); end
        tests++; if (vs_bad_run != 0) begin fails++; $display("FAIL vs_width: %0d pulses off, want 0", vs_bad_run); end
    endtask

    task automatic test_address;
        wait_hv(WX - 1, 43); step;
        tests++; if ({alph1, dH1, dV1} !== {5'd16, 3'd0, 4'd0}) begin fails++; $display("FAIL addr_left_out: got alph=%0d dH=%0d dV=%0d want 16 0 0", alph1, dH1, dV1); end
        step;
        tests++; if ({alph1, dH1, dV1} !== {5'd1, 3'd0, 4'd7}) begin fails++; $display("FAIL addr_left_in: got alph=%0d dH=%0d dV=%0d want 1 0 7", alph1, dH1, dV1); end
        wait_hv(WX + 3 * 8 + 5, WY + 2 * 16 + 7); step;
        tests++; if ({alph1, dH1, dV1} !== {5'd4, 3'd5, 4'd7}) begin fails++; $display("FAIL addr_main: got alph=%0d dH=%0d dV=%0d want 4 5 7", alph1, dH1, dV1); end
        wait_hv(WX + 63, 43); step;
        tests++; if ({alph1, dH1} !== {5'd8, 3'd7}) begin fails++; $display("FAIL addr_right_in: got alph=%0d dH=%0d want 8 7", alph1, dH1); end
        step;
        tests++; if ({alph1, dH1, dV1} !== {5'd16, 3'd0, 4'd0}) begin fails++; $display("FAIL addr_right_out: got alph=%0d dH=%0d dV=%0d want 16 0 0", alph1, dH1, dV1); end
        wait_hv(33, WY + 127); step;
        tests++; if ({alph1, dH1, dV1} !== {5'd12, 3'd5, 4'd15}) begin fails++; $display("FAIL addr_bottom_in: got alph=%0d dH=%0d dV=%0d want 12 5 15", alph1, dH1, dV1); end
        wait_hv(33, WY + 128); step;
        tests++; if (alph1 !== 5'd16) begin fails++; $display("FAIL addr_bottom_out: got alph=%0d want 16", alph1); end
    endtask

    task automatic test_colour;
        wait_hv(3, 133); step; step;
        tests++; if (rgb1 !== BGC) begin fails++; $display("FAIL col_active_bg: got %h want %h", rgb1, BGC); end
        wait_hv(HA - 1, 135); step; step;
        tests++; if (rgb1 !== BGC) begin fails++; $display("FAIL col_last_active: got %h want %h", rgb1, BGC); end
        step;
        tests++; if (rgb1 !== 12'h000) begin fails++; $display("FAIL col_hblank: got %h want 000", rgb1); end
        wait_hv(10, VA); step; step;
        tests++; if (rgb1 !== 12'h000) begin fails++; $display("FAIL col_vblank: got %h want 000", rgb1); end
        wait_hv(WX - 1, 10); step; step;
        tests++; if (rgb1 !== BGC) begin fails++; $display("FAIL col_left_bg: got %h want %h", rgb1, BGC); end
        step;
        tests++; if (rgb1 !== FGC) begin fails++; $display("FAIL col_left_fg: got %h want %h", rgb1, FGC); end
        wait_hv(WX + 63, 30); step; step;
        tests++; if (rgb1 !== FGC) begin fails++; $display("FAIL col_right_fg: got %h want %h", rgb1, FGC); end
        step;
        tests++; if (rgb1 !== BGC) begin fails++; $display("FAIL col_right_bg: got %h want %h", rgb1, BGC); end
    endtask

    task automatic test_snapshot;
        int fs0;
        fs0 = fs_cnt;
        words1[2*32 +: 32] = 32'h9ABC_DEF0;
        words1[6*32 +: 32] = 32'h55AA_33CC;
        wait_hv(33, 43); step;
        tests++; if (alph1 !== 5'd4) begin fails++; $display("FAIL snap_old_row2: got %0d want 4", alph1); end
        wait_hv(33, 100); step;
        tests++; if ({alph1, dV1} !== {5'd14, 4'd0}) begin fails++; $display("FAIL snap_old_row6: got alph=%0d dV=%0d want 14 0", alph1, dV1); end
        wait_hv(0, VA + VF); step;
        tests++; if (fs1 !== 1'b1) begin fails++; $display("FAIL snap_pulse_hi: got %b want 1", fs1); end
        step;
        tests++; if (fs1 !== 1'b0) begin fails++; $display("FAIL snap_pulse_lo: got %b want 0", fs1); end
        wait_hv(33, 43); step;
        tests++; if (alph1 !== 5'd12) begin fails++; $display("FAIL snap_new_row2: got %0d want 12", alph1); end
        wait_hv(33, 100); step;
        tests++; if (alph1 !== 5'd10) begin fails++; $display("FAIL snap_new_row6: got %0d want 10", alph1); end
        tests++; if (fs_cnt - fs0 != 1) begin fails++; $display("FAIL snap_pulse_count: got %0d want 1", fs_cnt - fs0); end
    endtask

    task automatic test_clkdiv_reset;
        int first, bad, guard;
        logic [25:0] prev, cur;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            rst4 = 1'b0;
            first = 0; bad = 0;
            prev = {rgb4, hs4, vs4, dH4, dV4, alph4};
            for (int n = 1; n <= 400; n++) begin
                step;
                cur = {rgb4, hs4, vs4, dH4, dV4, alph4};
                if (cur !== prev && (n % 4) != 0) bad++;
                if (first == 0 && hs4 === 1'b0) first = n;
                prev = cur;
            end
            tests++; if (bad != 0) begin fails++; $display("FAIL div4_off_tick: %0d changes off tick, want 0 (pass %0d)", bad, pass); end
            tests++; if (first != 4 * (HA + HF + 2)) begin fails++; $display("FAIL div4_first_hs: got %0d want %0d (pass %0d)", first, 4 * (HA + HF + 2), pass); end
            if (pass == 0) begin
                guard = 0;
                while (cyc4 < 4 * (10 * HT + 40) + 2 && guard < 20000) begin step; guard++; end
                tests++; if ({rgb4, alph4} !== {FGC, 5'd0}) begin fails++; $display("FAIL div4_midframe: got rgb=%h alph=%0d want %h 0", rgb4, alph4, FGC); end
                #1 rst4 = 1'b1;
                #1;
                tests++; if ({rgb4, hs4, vs4} !== {12'h000, 2'b11}) begin fails++; $display("FAIL div4_async_rst_out: got rgb=%h hs=%b vs=%b want 000 1 1", rgb4, hs4, vs4); end
                tests++; if ({alph4, dH4, dV4, fs4} !== {5'd16, 8'd0}) begin fails++; $display("FAIL div4_async_rst_addr: got alph=%0d dH=%0d dV=%0d fs=%b want 16 0 0 0", alph4, dH4, dV4, fs4); end
                repeat (3) step;
            end
        end
    endtask

    initial begin
        words1[0*32 +: 32] = 32'h0123_4567;
        words1[2*32 +: 32] = 32'h1234_5678;
        words1[6*32 +: 32] = 32'h0F1E_2D3C;
        words1[7*32 +: 32] = 32'hFEDC_BA98;
        test_reset;
        test_timing;
        test_address;
        test_colour;
        test_snapshot;
        test_clkdiv_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_hex_text_scan.md
Name: vga_hex_text_scan

Overview:
- Raster scanner that drives a VGA 640x480@60 text window and reads the 8x16 character glyph ROM.
- Generates sync timing and glyph ROM addresses (dH, dV, alph), takes back the glyph pixel, and produces registered RGB.
- Shows an 8x8 block of hex digits: eight 32-bit debug words, one word per text row, MSB nibble leftmost.
- Words are snapshotted once per frame so the picture never tears.

Parameters:
- CLK_DIV, 4, system clocks per pixel; 1 means every cycle is a pixel tick.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.
- WIN_X, 256, left pixel column of the text window.
- WIN_Y, 176, top pixel line of the text window.
- FG, 12'hFFF, foreground colour.
- BG, 12'h000, window background colour.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- words  in  256  eight words; row r = words[32r+31:32r]
- dH  out  3  glyph column to ROM
- dV  out  4  glyph row to ROM
- alph  out  5  glyph code to ROM; 0-15 = hex digit, 16 = space
- point  in  1  glyph pixel from ROM; combinational response to dH/dV/alph
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- rgb  out  12  {R4,G4,B4}
- frame_start  out  1  one-clock pulse when the snapshot is taken

Behaviour:
- Reset: div=0, hcnt=0, vcnt=0, hs=1, vs=1, rgb=0, dH=0, dV=0, alph=16, snapshot=0, frame_start=0.
- Reset asserted mid-frame restarts the scan at (0,0) with no partial output.
- tick is high when div==CLK_DIV-1; div wraps to 0. Every register below updates only on tick, except frame_start, which is a plain pulse.
- Stage 0 counters:
  - hcnt counts 0..HT-1 with HT = sum of the H parameters (800).
  - At hcnt wrap, vcnt increments through 0..VT-1 (525) and wraps to 0.
- Stage 1 (registered):
  - in_win = hcnt in [WIN_X, WIN_X+64) and vcnt in [WIN_Y, WIN_Y+128).
  - col = (hcnt-WIN_X)>>3, row = (vcnt-WIN_Y)>>4.
  - dH = (hcnt-WIN_X)[2:0], dV = (vcnt-WIN_Y)[3:0].
  - alph = snapshot[row][31-4col -: 4] when in_win, else 16, with dH=dV=0.
  - act1 = hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - hs1 = !(hcnt in [H_ACTIVE+H_FP, +H_SYNC)); vs1 likewise on vcnt.
- Stage 2 (registered):
  - rgb = act1 ? (point ? FG : BG) : 0.
  - hs = hs1, vs = vs1.
- Latency: a pixel at count (h,v) appears on rgb/hs/vs exactly 2 ticks later. Sync and colour stay aligned.
- Snapshot:
  - Trigger: the tick with hcnt==0 and vcnt==V_ACTIVE+V_FP, i.e. start of the vsync line.
  - On the trigger, snapshot <= words and frame_start pulses for 1 clk.
  - Input changes at any other time have no visible effect until the next trigger.
- point is sampled only on stage-2 ticks. It must be stable one clock after dH/dV/alph change; the ROM is combinational, so this holds.
- All subtractions are evaluated only inside the window, so no negative wrap is used.
- col and row are 3 bits.

Decomposition:
- Shared package vga_pkg:
  - timing defaults;
  - CHAR_W=8, CHAR_H=16;
  - ALPH_SPACE=5'd16;
  - hex digit helper.
- One sub-module, vga_timing: divider, hcnt/vcnt, tick, raw sync, active and snapshot trigger.
- The parent holds the snapshot, address stage and colour stage.

Test Plan:
- Reset: rgb=0, hs=vs=1 and alph=16 during reset. With CLK_DIV=1, the first hs falling edge occurs exactly 656+2 clocks after reset release.
- Timing (CLK_DIV=1): hs low for 96 clocks per 800-clock line. vs low for 2 lines (1600 clocks) per 525 lines. Line and frame periods stay exact across 3 frames.
- Address (CLK_DIV=1):
  - Setup: words row2=32'h12345678, captured at the snapshot trigger.
  - At h=WIN_X+3*8+5=285, v=WIN_Y+2*16+7=215: one tick later dH=5, dV=7, alph=4.
  - Outside the window alph=16.
- Colour: a ROM model returning point=1 gives rgb=FG two ticks after an in-window count, BG elsewhere in the active area, and 0 during blanking.
- Snapshot: change words mid-frame; alph keeps the old digits until the trigger; frame_start pulses once per frame and the new digits appear on the next frame.
- CLK_DIV=4 plus mid-frame reset: outputs change only on ticks. Asserting rst at v=300 returns all outputs to reset values immediately, with no clock needed. The scan resumes from (0,0).
